// File: rtl/alu_arbiter.sv
// Round-robin sequencer that shares one combinational ALU between two requesters.
// Optional DIV-by-zero trap is compiled in with `define ALU_ARB_DIVZERO_EN.
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [3:0]  req0_cmd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [3:0]  req1_cmd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_command,
    output logic        alu_enable,
    input  logic [15:0] alu_y
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);
    localparam logic [3:0] CMD_DIV = 4'b0101;

    logic [1:0] state;
    logic       ptr;
    logic [3:0] cnt;

    logic       sel_valid;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [3:0] sel_cmd;
    logic       div_zero;
    logic       any_valid;

    // Ready is registered, so the grant is decided one cycle ahead and the
    // transfer is taken on the edge that closes the ready cycle.
    function automatic logic pick(input logic p, input logic v0, input logic v1);
        if (p)
            pick = v1 ? 1'b1 : 1'b0;
        else
            pick = v0 ? 1'b0 : 1'b1;
    endfunction

    assign any_valid = req0_valid | req1_valid;
    assign sel_valid = req1_ready ? req1_valid : req0_valid;
    assign sel_a     = req1_ready ? req1_a     : req0_a;
    assign sel_b     = req1_ready ? req1_b     : req0_b;
    assign sel_cmd   = req1_ready ? req1_cmd   : req0_cmd;

`ifdef ALU_ARB_DIVZERO_EN
    assign div_zero = (sel_cmd == CMD_DIV) && (sel_b == 8'd0);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= RR_INIT;
            cnt         <= 4'd0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 16'd0;
            rsp_id      <= 1'b0;
            rsp_err     <= 1'b0;
            alu_a       <= 8'd0;
            alu_b       <= 8'd0;
            alu_command <= 4'd0;
            alu_enable  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        req0_ready <= 1'b0;
                        req1_ready <= 1'b0;
                        // A requester that dropped valid during its ready cycle is simply skipped.
                        if (sel_valid) begin
                            rsp_id <= req1_ready;
                            if (div_zero) begin
                                rsp_data  <= 16'hFFFF;
                                rsp_err   <= 1'b1;
                                rsp_valid <= 1'b1;
                                state     <= S_RESP;
                            end else begin
                                alu_a       <= sel_a;
                                alu_b       <= sel_b;
                                alu_command <= sel_cmd;
                                alu_enable  <= 1'b1;
                                state       <= S_EXEC;
                            end
                        end
                    end else if (any_valid) begin
                        if (pick(ptr, req0_valid, req1_valid))
                            req1_ready <= 1'b1;
                        else
                            req0_ready <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (LAT_M1 == 4'd0) begin
                        rsp_data   <= alu_y;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        alu_enable <= 1'b0;
                        state      <= S_RESP;
                    end else begin
                        cnt   <= LAT_M1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_data   <= alu_y;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        alu_enable <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                default: begin
                    // Granting on the handshake edge keeps the issue interval at ALU_LAT+2.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~rsp_id;
                        state     <= S_IDLE;
                        if (any_valid) begin
                            if (pick(~rsp_id, req0_valid, req1_valid))
                                req1_ready <= 1'b1;
                            else
                                req0_ready <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a single-cycle instance driven from a vector
// table and hand sequences, plus a three-cycle-latency instance.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural stand-in for the shared ALU; y is 0 whenever enable is low.
    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] cmd, input logic en);
        if (!en) return 16'h0000;
        case (cmd)
            4'h0: return {8'h00, a} + {8'h00, b};
            4'h1: return {8'h00, a} - {8'h00, b};
            4'h2: return {8'h00, a} * {8'h00, b};
            4'h3: return {8'h00, a & b};
            4'h4: return {8'h00, a | b};
            4'h5: return (b == 8'd0) ? 16'hDEAD : {8'h00, a / b};
            4'hF: return {8'h00, a};
            default: return 16'h0000;
        endcase
    endfunction

    logic        f_rst_n;
    logic [1:0]  f_valid, f_ready;
    logic [7:0]  f_a [2];
    logic [7:0]  f_b [2];
    logic [3:0]  f_cmd [2];
    logic        f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_err, f_alu_en;
    logic [15:0] f_rsp_data, f_alu_y;
    logic [7:0]  f_alu_a, f_alu_b;
    logic [3:0]  f_alu_cmd;

    assign f_alu_y = alu_model(f_alu_a, f_alu_b, f_alu_cmd, f_alu_en);

    alu_arbiter #(.ALU_LAT(1), .RR_INIT(1'b0)) u_fast (
        .clk(clk), .rst_n(f_rst_n),
        .req0_valid(f_valid[0]), .req0_ready(f_ready[0]),
        .req0_a(f_a[0]), .req0_b(f_b[0]), .req0_cmd(f_cmd[0]),
        .req1_valid(f_valid[1]), .req1_ready(f_ready[1]),
        .req1_a(f_a[1]), .req1_b(f_b[1]), .req1_cmd(f_cmd[1]),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data),
        .rsp_id(f_rsp_id), .rsp_err(f_rsp_err),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_command(f_alu_cmd),
        .alu_enable(f_alu_en), .alu_y(f_alu_y)
    );

    logic        s_rst_n;
    logic [1:0]  s_valid, s_ready;
    logic [7:0]  s_a [2];
    logic [7:0]  s_b [2];
    logic [3:0]  s_cmd [2];
    logic        s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_err, s_alu_en;
    logic [15:0] s_rsp_data, s_alu_y;
    logic [7:0]  s_alu_a, s_alu_b;
    logic [3:0]  s_alu_cmd;

    assign s_alu_y = alu_model(s_alu_a, s_alu_b, s_alu_cmd, s_alu_en);

    alu_arbiter #(.ALU_LAT(3), .RR_INIT(1'b1)) u_slow (
        .clk(clk), .rst_n(s_rst_n),
        .req0_valid(s_valid[0]), .req0_ready(s_ready[0]),
        .req0_a(s_a[0]), .req0_b(s_b[0]), .req0_cmd(s_cmd[0]),
        .req1_valid(s_valid[1]), .req1_ready(s_ready[1]),
        .req1_a(s_a[1]), .req1_b(s_b[1]), .req1_cmd(s_cmd[1]),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
        .rsp_id(s_rsp_id), .rsp_err(s_rsp_err),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_command(s_alu_cmd),
        .alu_enable(s_alu_en), .alu_y(s_alu_y)
    );

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  cmd;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    // One complete operation on the single-cycle instance, checking grant, latency and response.
    task automatic apply_stimulus(input int id, input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] cmd, input logic [15:0] exp_data,
                                  input logic exp_err, input int exp_lat, input logic exp_en);
        int   n;
        logic seen;
        logic en_seen;
        @(negedge clk);
        f_a[id] = a; f_b[id] = b; f_cmd[id] = cmd; f_valid[id] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = f_ready[id];
        end
        check_output("grant_seen", 32'(seen), 32'd1);
        check_output("other_ready_low", 32'(f_ready[1-id]), 32'd0);
        @(posedge clk); #1;
        f_valid[id] = 1'b0;
        check_output("ready_one_cycle", 32'(f_ready), 32'd0);
        n = 1;
        en_seen = f_alu_en;
        seen = f_rsp_valid;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            en_seen = en_seen | f_alu_en;
            seen = f_rsp_valid;
        end
        check_output("rsp_latency", 32'(n), 32'(exp_lat));
        check_output("rsp_data", 32'(f_rsp_data), 32'(exp_data));
        check_output("rsp_id", 32'(f_rsp_id), 32'(id));
        check_output("rsp_err", 32'(f_rsp_err), 32'(exp_err));
        check_output("alu_enable_used", 32'(en_seen), 32'(exp_en));
        @(posedge clk); #1;
        check_output("rsp_consumed", 32'(f_rsp_valid), 32'd0);
        if (exp_en) check_output("alu_a_held", 32'(f_alu_a), 32'(a));
    endtask

    // Operation on the three-cycle instance; reports what it observed for the caller to check.
    task automatic slow_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                           output int n, output int en_cnt, output logic stable);
        logic seen;
        @(negedge clk);
        s_a[id] = a; s_b[id] = b; s_cmd[id] = cmd; s_valid[id] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = s_ready[id];
        end
        @(posedge clk); #1;
        s_valid[id] = 1'b0;
        n = 1; en_cnt = 0; stable = 1'b1;
        seen = s_rsp_valid;
        while (!seen && n < 20) begin
            if (s_alu_en) begin
                en_cnt++;
                if (s_alu_a !== a || s_alu_b !== b || s_alu_cmd !== cmd) stable = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            seen = s_rsp_valid;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n, en_cnt, got, ng, both;
        logic        stable, rdy_seen;
        logic [15:0] rd [4];
        logic        ri [4];
        int          gcyc [4];

        vecs[0] = '{0, 8'd20,  8'd10,  4'h0, 16'd30};
        vecs[1] = '{1, 8'd25,  8'd17,  4'h1, 16'd8};
        vecs[2] = '{0, 8'd15,  8'd15,  4'h2, 16'd225};
        vecs[3] = '{1, 8'd255, 8'd255, 4'h2, 16'hFE01};
        vecs[4] = '{0, 8'hF0,  8'h0F,  4'h4, 16'h00FF};
        vecs[5] = '{1, 8'd200, 8'd7,   4'h5, 16'd28};
        vecs[6] = '{0, 8'hAA,  8'h00,  4'hF, 16'h00AA};
        vecs[7] = '{1, 8'd0,   8'd1,   4'h1, 16'hFFFF};

        f_rst_n = 1'b0; s_rst_n = 1'b0;
        f_valid = 2'b00; s_valid = 2'b00;
        f_rsp_ready = 1'b1; s_rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            f_a[i] = 8'd0; f_b[i] = 8'd0; f_cmd[i] = 4'd0;
            s_a[i] = 8'd0; s_b[i] = 8'd0; s_cmd[i] = 4'd0;
        end
        #2;
        check_output("reset_ready", 32'(f_ready), 32'd0);
        check_output("reset_rsp_valid", 32'(f_rsp_valid), 32'd0);
        check_output("reset_rsp_data", 32'(f_rsp_data), 32'd0);
        check_output("reset_alu_en", 32'(f_alu_en), 32'd0);
        check_output("reset_alu_a", 32'(f_alu_a), 32'd0);
        @(negedge clk); @(negedge clk);
        f_rst_n = 1'b1; s_rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            apply_stimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].exp, 1'b0, 2, 1'b1);

`ifdef ALU_ARB_DIVZERO_EN
        apply_stimulus(0, 8'd20, 8'd0, 4'h5, 16'hFFFF, 1'b1, 1, 1'b0);
`else
        apply_stimulus(0, 8'd20, 8'd0, 4'h5, 16'hDEAD, 1'b0, 2, 1'b1);
`endif
        apply_stimulus(1, 8'd9, 8'd4, 4'h3, 16'h0000, 1'b0, 2, 1'b1);

        // Contention from a fresh reset: req0 holds priority, grants alternate every 3 cycles.
        @(negedge clk); f_rst_n = 1'b0;
        @(negedge clk); f_rst_n = 1'b1;
        f_a[0] = 8'd15; f_b[0] = 8'd15; f_cmd[0] = 4'h2;
        f_a[1] = 8'd25; f_b[1] = 8'd17; f_cmd[1] = 4'h1;
        f_valid = 2'b11;
        got = 0; ng = 0; both = 0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(posedge clk); #1;
            if (f_ready == 2'b11) both++;
            if (f_ready != 2'b00 && ng < 4) begin
                gcyc[ng] = cyc;
                ng++;
            end
            if (f_rsp_valid) begin
                rd[got] = f_rsp_data;
                ri[got] = f_rsp_id;
                got++;
            end
        end
        f_valid = 2'b00;
        check_output("contention_count", 32'(got), 32'd4);
        check_output("contention_both_ready", 32'(both), 32'd0);
        if (got == 4) begin
            check_output("contention_id0", 32'(ri[0]), 32'd0);
            check_output("contention_id1", 32'(ri[1]), 32'd1);
            check_output("contention_id2", 32'(ri[2]), 32'd0);
            check_output("contention_id3", 32'(ri[3]), 32'd1);
            check_output("contention_data0", 32'(rd[0]), 32'd225);
            check_output("contention_data1", 32'(rd[1]), 32'd8);
            check_output("contention_data2", 32'(rd[2]), 32'd225);
            check_output("issue_interval", 32'(gcyc[1] - gcyc[0]), 32'd3);
        end
        @(posedge clk); @(posedge clk);

        // Backpressure: response held for 5 cycles while req1 waits without a grant.
        @(negedge clk);
        f_rsp_ready = 1'b0;
        f_a[0] = 8'd3; f_b[0] = 8'd4; f_cmd[0] = 4'h0; f_valid[0] = 1'b1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 10 && !rdy_seen; i++) begin
            @(posedge clk); #1;
            rdy_seen = f_ready[0];
        end
        @(posedge clk); #1;
        f_valid[0] = 1'b0;
        f_a[1] = 8'd1; f_b[1] = 8'd1; f_cmd[1] = 4'h0; f_valid[1] = 1'b1;
        for (int i = 0; i < 10 && !f_rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check_output("bp_rsp_valid", 32'(f_rsp_valid), 32'd1);
        stable = 1'b1; rdy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!f_rsp_valid || f_rsp_data !== 16'd7 || f_rsp_id !== 1'b0) stable = 1'b0;
            if (f_ready != 2'b00) rdy_seen = 1'b1;
        end
        check_output("bp_stable", 32'(stable), 32'd1);
        check_output("bp_no_ready", 32'(rdy_seen), 32'd0);
        check_output("bp_data", 32'(f_rsp_data), 32'd7);
        @(negedge clk); f_rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_output("bp_released", 32'(f_rsp_valid), 32'd0);
        check_output("bp_next_grant", 32'(f_ready), 32'b10);
        @(posedge clk); #1;
        f_valid[1] = 1'b0;
        for (int i = 0; i < 10 && !f_rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check_output("bp_req1_data", 32'(f_rsp_data), 32'd2);
        check_output("bp_req1_id", 32'(f_rsp_id), 32'd1);

        // Three-cycle ALU latency.
        slow_op(1, 8'hF0, 8'h0F, 4'h4, n, en_cnt, stable);
        check_output("lat3_latency", 32'(n), 32'd4);
        check_output("lat3_enable_cycles", 32'(en_cnt), 32'd3);
        check_output("lat3_inputs_stable", 32'(stable), 32'd1);
        check_output("lat3_data", 32'(s_rsp_data), 32'h00FF);
        check_output("lat3_id", 32'(s_rsp_id), 32'd1);
        @(posedge clk); #1;

        // Reset while waiting on the ALU abandons the operation.
        @(negedge clk);
        s_a[0] = 8'd5; s_b[0] = 8'd6; s_cmd[0] = 4'h0; s_valid[0] = 1'b1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 10 && !rdy_seen; i++) begin
            @(posedge clk); #1;
            rdy_seen = s_ready[0];
        end
        @(posedge clk); #1;
        s_valid[0] = 1'b0;
        @(posedge clk); #2;
        s_rst_n = 1'b0;
        #1;
        check_output("midrst_alu_en", 32'(s_alu_en), 32'd0);
        check_output("midrst_alu_a", 32'(s_alu_a), 32'd0);
        check_output("midrst_rsp_valid", 32'(s_rsp_valid), 32'd0);
        check_output("midrst_ready", 32'(s_ready), 32'd0);
        @(negedge clk); s_rst_n = 1'b1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (s_rsp_valid) rdy_seen = 1'b1;
        end
        check_output("midrst_no_rsp", 32'(rdy_seen), 32'd0);
        slow_op(0, 8'd9, 8'd9, 4'h0, n, en_cnt, stable);
        check_output("postrst_latency", 32'(n), 32'd4);
        check_output("postrst_data", 32'(s_rsp_data), 32'd18);
        check_output("postrst_id", 32'(s_rsp_id), 32'd0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequencer/arbiter that shares one combinational 8-bit ALU (a, b, command, enable -> y[15:0]) between two requesters.
- Accepts operations over valid/ready and grants round-robin.
- Drives the ALU operands, command and enable; waits a configurable settle time; captures y; returns the result with the requester ID over a valid/ready response channel.
- Sits between the bus-side masters and the alu instance.

Parameters:
- ALU_LAT, 1: cycles the ALU inputs are held stable before y is sampled (1..15).
- RR_INIT, 0: requester holding priority after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  8  operand a, requester 0
- req0_b  in  8  operand b, requester 0
- req0_cmd  in  4  ALU command, requester 0 (0000 ADD ... 0101 DIV ... 1111 BUF)
- req1_valid, req1_ready, req1_a, req1_b, req1_cmd  (same widths)  requester 1 equivalents
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  captured ALU result
- rsp_id  out  1  requester that issued the operation
- rsp_err  out  1  error flag (see Optional Feature)
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_command  out  4  to ALU command
- alu_enable  out  1  to ALU enable
- alu_y  in  16  from ALU y

Behaviour:
- Reset (async, rst_n=0), all outputs registered:
  - req*_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0
  - alu_a=0, alu_b=0, alu_command=0, alu_enable=0
  - state=IDLE, priority pointer=RR_INIT.
- States: IDLE -> EXEC -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any reqN_valid, pick the winner: the requester the pointer favours if it is valid, else the other one.
  - Pulse the winner's req_ready for exactly one cycle; the transfer happens on that cycle.
  - Register a/b/cmd into alu_*, set alu_enable=1, latch the winner ID, go to EXEC.
  - Never assert both readys in the same cycle.
- EXEC/WAIT:
  - alu_* held stable and alu_enable=1.
  - Internal counter loads ALU_LAT-1 in EXEC and decrements in WAIT.
  - When the counter reaches 0, sample alu_y into rsp_data, set rsp_valid=1, alu_enable=0, go to RESP.
  - With ALU_LAT=1, WAIT lasts zero cycles: sampling happens on the EXEC->RESP edge.
- RESP:
  - rsp_valid, rsp_data, rsp_id, rsp_err held stable until rsp_ready=1.
  - On the handshake: rsp_valid=0, priority pointer toggles to the other requester (whether or not it was waiting), go to IDLE.
- Latency, accept to rsp_valid: ALU_LAT+1 cycles. Minimum issue interval: ALU_LAT+2 cycles with rsp_ready tied high.
- One operation in flight; no new req_ready while the FSM is outside IDLE.
- Simultaneous valids: pointer holder wins. Back-to-back contention strictly alternates 0,1,0,1.
- A request withdrawn before ready is not an error; no grant is issued for it.
- alu_a/alu_b/alu_command keep their last values when idle; only alu_enable drops.
- rsp_data is the full 16-bit alu_y, not truncated, for all commands (MUL uses all 16 bits).
- Reset mid-operation: the operation is abandoned, no response is produced, state returns to the reset values immediately.

Optional Feature:
- Macro: ALU_ARB_DIVZERO_EN.
- Defined: a granted command 4'b0101 (DIV) with b==0 does not drive the ALU.
  - alu_enable stays 0; the FSM goes IDLE -> RESP on the next cycle.
  - Response: rsp_data=16'hFFFF, rsp_err=1.
  - rsp_err=0 for every other response.
- Undefined: the DIV-by-zero check is not compiled.
  - The operation is sent to the ALU like any other and its raw y is returned.
  - rsp_err is tied 0.

Test Plan:
- Single op, ALU_LAT=1: req0 a=20, b=10, cmd ADD -> req0_ready for 1 cycle; rsp_valid 2 cycles later; rsp_data=16'd30, rsp_id=0.
- Contention, RR_INIT=0: both valid and held, req0 MUL 15*15, req1 SUB 25-17 -> first rsp 16'd225 id 0, then 16'd8 id 1, then grants alternate.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable; both req*_ready stay 0; completes when rsp_ready=1.
- ALU_LAT=3: req1 a=8'hF0, b=8'h0F, cmd OR -> alu_enable high 3 cycles, inputs stable; rsp_data=16'h00FF at accept+4.
- Reset mid-op: assert rst_n=0 during WAIT -> all outputs 0 asynchronously; no rsp_valid after release; next request served normally.
- DivZero (macro on): req0 a=20, b=0, cmd DIV -> alu_enable never 1; rsp_data=16'hFFFF, rsp_err=1. Macro off: rsp_err=0 and rsp_data=alu_y.
